seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a NUM_DIGITS common-segment 7-segment display.
- Holds one 5-bit character code per digit and scans the digits one at a time.
- Decodes each code to a pattern covering hex digits plus the menu/status letters used by the drink-selection UI.
- Supports a per-digit blink mask; new messages take effect on frame boundaries so the display never tears.

---
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment display driver with frame-synchronous
// message loading and per-digit blinking.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   load       capture charsIn/blinkMask this cycle
//   charsIn    5-bit code per digit, digit i in bits [5i+4:5i]
//   blinkMask  bit i=1 makes digit i blink
//   blinkEn    global blink enable, sampled live
//   segOut     registered segment pattern, bit0=a .. bit6=g
//   digitEn    registered one-hot digit enable
//   loadAck    one-cycle pulse when pending data becomes visible
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int BLINK_FRAMES     = 250,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] charsIn,
    input  logic [NUM_DIGITS-1:0]   blinkMask,
    input  logic                    blinkEn,
    output logic [6:0]              segOut,
    output logic [NUM_DIGITS-1:0]   digitEn,
    output logic                    loadAck
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [5*NUM_DIGITS-1:0] BLANK_ALL = {NUM_DIGITS{5'd16}};

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'h3F;
            5'd1:    decode = 7'h06;
            5'd2:    decode = 7'h5B;
            5'd3:    decode = 7'h4F;
            5'd4:    decode = 7'h66;
            5'd5:    decode = 7'h6D;
            5'd6:    decode = 7'h7D;
            5'd7:    decode = 7'h07;
            5'd8:    decode = 7'h7F;
            5'd9:    decode = 7'h6F;
            5'd10:   decode = 7'h77;
            5'd11:   decode = 7'h7C;
            5'd12:   decode = 7'h39;
            5'd13:   decode = 7'h5E;
            5'd14:   decode = 7'h79;
            5'd15:   decode = 7'h71;
            5'd17:   decode = 7'h40;
            5'd18:   decode = 7'h38;
            5'd19:   decode = 7'h73;
            5'd20:   decode = 7'h50;
            5'd21:   decode = 7'h54;
            5'd22:   decode = 7'h5C;
            5'd23:   decode = 7'h3E;
            5'd24:   decode = 7'h76;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    off_q, off_d;
    logic [5*NUM_DIGITS-1:0] disp_q, disp_d, pch_q, pch_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d, pmk_q, pmk_d;
    logic                    pend_q, pend_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    ack_q, ack_d;
    logic                    wrap, last, boundary, fwrap, blank;
    logic [4:0]              code_d;

    always_comb begin
        wrap     = presc_q == PW'(SCAN_DIV - 1);
        last     = idx_q == IW'(NUM_DIGITS - 1);
        boundary = wrap && last;
        fwrap    = frame_q == FW'(BLINK_FRAMES - 1);
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        idx_d    = wrap ? (last ? '0 : idx_q + 1'b1) : idx_q;
        frame_d  = boundary ? (fwrap ? '0 : frame_q + 1'b1) : frame_q;
        off_d    = (boundary && fwrap) ? ~off_q : off_q;
        // A load on the boundary edge wins over older pending data.
        disp_d   = boundary ? (load ? charsIn : pend_q ? pch_q : disp_q) : disp_q;
        blink_d  = boundary ? (load ? blinkMask : pend_q ? pmk_q : blink_q) : blink_q;
        pend_d   = boundary ? 1'b0 : (load ? 1'b1 : pend_q);
        pch_d    = (!boundary && load) ? charsIn : pch_q;
        pmk_d    = (!boundary && load) ? blinkMask : pmk_q;
        ack_d    = boundary && (load || pend_q);
        // Outputs are built from next-state values so the new digit appears on the wrap edge.
        code_d   = disp_d[5*int'(idx_d) +: 5];
        blank    = blinkEn && off_d && blink_d[idx_d];
        seg_d    = (blank ? 7'h00 : decode(code_d)) ^ {7{SEG_ACTIVE_LOW}};
        dig_d    = (NUM_DIGITS'(1) << idx_d) ^ {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            off_q   <= 1'b0;
            disp_q  <= BLANK_ALL;
            blink_q <= '0;
            pch_q   <= BLANK_ALL;
            pmk_q   <= '0;
            pend_q  <= 1'b0;
            seg_q   <= {7{SEG_ACTIVE_LOW}};
            dig_q   <= NUM_DIGITS'(1) ^ {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
            ack_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            off_q   <= off_d;
            disp_q  <= disp_d;
            blink_q <= blink_d;
            pch_q   <= pch_d;
            pmk_q   <= pmk_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            ack_q   <= ack_d;
        end
    end

    assign segOut  = seg_q;
    assign digitEn = dig_q;
    assign loadAck = ack_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized check of seg7_scan_driver against a time-based reference model.
module tb_seg7_scan_driver;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BF = 2;
    localparam int FR = N * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0;
    logic        blink_en = 1'b0;
    logic [19:0] chars_in = '0;
    logic [3:0]  mask_in = '0;
    logic [6:0]  seg, seg_n;
    logic [3:0]  dig, dig_n;
    logic        ack, ack_n;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF)) dut (
        .clock(clk), .reset(rst), .load(load_i), .charsIn(chars_in), .blinkMask(mask_in),
        .blinkEn(blink_en), .segOut(seg), .digitEn(dig), .loadAck(ack)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF),
                       .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)) dut_n (
        .clock(clk), .reset(rst), .load(load_i), .charsIn(chars_in), .blinkMask(mask_in),
        .blinkEn(blink_en), .segOut(seg_n), .digitEn(dig_n), .loadAck(ack_n)
    );

    int tests = 0;
    int fails = 0;

    string tbl [32] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg",
                        "", "g", "def", "abefg", "eg", "ceg", "cdeg", "bcdef",
                        "bcefg", "", "", "", "", "", "", ""};

    // Reference state: edges since reset plus what the display should hold.
    int       k;
    int       disp [N];
    int       pch  [N];
    logic [3:0] bl, pmk;
    bit       pend, ack_e;

    function automatic logic [6:0] dec(input int code);
        string      s = tbl[code];
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, got, exp, k, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < N; i++) disp[i] = 16;
        bl    = '0;
        pend  = 1'b0;
        ack_e = 1'b0;
    endtask

    task automatic check_outputs();
        int         d   = (k / S) % N;
        bit         off = ((k / FR) / BF) % 2 == 1;
        logic [6:0] es  = (blink_en && off && bl[d]) ? 7'h00 : dec(disp[d]);
        logic [3:0] ed  = 4'(1 << d);
        chk("seg", 32'(seg), 32'(es));
        chk("dig", 32'(dig), 32'(ed));
        chk("ack", 32'(ack), 32'(ack_e));
        chk("seg_n", 32'(seg_n), 32'(es ^ 7'h7F));
        chk("dig_n", 32'(dig_n), 32'(ed ^ 4'hF));
    endtask

    task automatic step(input bit ld, input logic [19:0] ch, input logic [3:0] mk);
        load_i   = ld;
        chars_in = ch;
        mask_in  = mk;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            k++;
            ack_e = 1'b0;
            if (k % FR == 0) begin
                if (ld) begin
                    for (int i = 0; i < N; i++) disp[i] = int'(ch[5*i +: 5]);
                    bl    = mk;
                    ack_e = 1'b1;
                end else if (pend) begin
                    disp  = pch;
                    bl    = pmk;
                    ack_e = 1'b1;
                end
                pend = 1'b0;
            end else if (ld) begin
                for (int i = 0; i < N; i++) pch[i] = int'(ch[5*i +: 5]);
                pmk  = mk;
                pend = 1'b1;
            end
        end
        check_outputs();
    endtask

    task automatic run_until(input int ph);
        for (int n = 0; n < FR && (k % FR) != ph; n++) step(1'b0, '0, '0);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_seg"}, 32'(seg), 32'h00);
        chk({tag, "_dig"}, 32'(dig), 32'h1);
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        step(1'b0, '0, '0);
        rst = 1'b0;
    endtask

    logic [6:0] ce0 [N] = '{7'b0111001, 7'b1111001, 7'b0111111, 7'b0000000};

    initial begin
        model_reset();
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dig", 32'(dig), 32'b0001);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dig_n", 32'(dig_n), 32'b1110);
        rst = 1'b0;
        repeat (FR + 2) step(1'b0, '0, '0);
        for (int n = 0; n < FR && !((k / S) % N == 2 && k % S == 1); n++) step(1'b0, '0, '0);
        async_reset_check("rst_mid");

        run_until(5);
        step(1'b1, {5'd16, 5'd0, 5'd14, 5'd12}, 4'b0000);
        run_until(0);
        chk("ce0_ack", 32'(ack), 32'h1);
        for (int i = 0; i < N; i++) begin
            chk("ce0_digit", 32'(seg), 32'(ce0[i]));
            repeat (S) step(1'b0, '0, '0);
        end

        run_until(3);
        step(1'b1, 20'd1, 4'b0000);
        step(1'b0, '0, '0);
        step(1'b1, 20'd2, 4'b0000);
        run_until(0);
        chk("two_load_d0", 32'(seg), 32'b1011011);
        repeat (FR) step(1'b0, '0, '0);

        run_until(FR - 1);
        step(1'b1, 20'd8, 4'b0000);
        chk("bnd_d0", 32'(seg), 32'h7F);
        chk("bnd_ack", 32'(ack), 32'h1);
        repeat (FR) step(1'b0, '0, '0);

        run_until(3);
        step(1'b1, 20'd6, 4'b0000);
        async_reset_check("rst_pend");
        repeat (2 * FR) step(1'b0, '0, '0);

        blink_en = 1'b1;
        run_until(FR - 1);
        step(1'b1, {4{5'd8}}, 4'b0010);
        repeat (4 * FR + 3) step(1'b0, '0, '0);
        blink_en = 1'b0;
        repeat (4 * FR) step(1'b0, '0, '0);

        for (int c = 0; c < 32; c++) begin
            run_until(7);
            step(1'b1, {15'd0, 5'(c)}, 4'b0000);
            run_until(0);
            chk("sweep", 32'(seg), 32'(dec(c)));
        end

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
            step($urandom_range(0, 9) == 0, 20'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
